// File: rtl/ptw_pkg.sv
// Shared types and constants for the page-table walker: FSM states, PTE field
// positions, bus geometry and the walker's bus tag.
package ptw_pkg;

  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 13;
  localparam int VA_WIDTH       = 48;
  localparam int MAX_LEVELS     = 4;
  localparam int VPN_BITS       = 9;
  localparam int PAGE_SHIFT     = 12;
  localparam int LINE_BEATS     = 8;

  localparam int PTE_V   = 0;
  localparam int PTE_R   = 1;
  localparam int PTE_W   = 2;
  localparam int PTE_X   = 3;
  localparam int PPN_LSB = 10;
  localparam int PPN_MSB = 53;

  localparam logic        SYSBUS_READ   = 1'b1;
  localparam logic [11:0] SYSBUS_MEMORY = 12'h001;
  localparam logic [BUS_TAG_WIDTH-1:0] PTW_TAG = {SYSBUS_READ, SYSBUS_MEMORY};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } ptw_state_e;

  // VPN slice of the virtual address that indexes the table at a given level.
  function automatic logic [VPN_BITS-1:0] vpn_at(input logic [VA_WIDTH-1:0] va,
                                                 input logic [1:0] level);
    return va[PAGE_SHIFT + VPN_BITS*int'(level) +: VPN_BITS];
  endfunction

endpackage

// File: rtl/pte_check.sv
// Combinational PTE evaluation for one walk level: leaf/fault decision, the
// translated PA for a leaf, and the next table base for a pointer PTE.
module pte_check
  import ptw_pkg::*;
(
  input  logic [BUS_DATA_WIDTH-1:0] pte,
  input  logic [1:0]                level,
  input  logic [VA_WIDTH-1:0]       va,
  output logic                      leaf,
  output logic                      fault,
  output logic [BUS_DATA_WIDTH-1:0] pa,
  output logic [BUS_DATA_WIDTH-1:0] next_base
);

  logic                      v, r, w, x;
  logic                      misaligned;
  logic [5:0]                off_bits;
  logic [BUS_DATA_WIDTH-1:0] page_base;
  logic [BUS_DATA_WIDTH-1:0] off_mask;
  logic [BUS_DATA_WIDTH-1:0] va_ext;
  logic                      unused_pte_bits;

  assign unused_pte_bits = ^{pte[BUS_DATA_WIDTH-1:PPN_MSB+1], pte[PPN_LSB-1:PTE_X+1]};

  always_comb begin
    v = pte[PTE_V];
    r = pte[PTE_R];
    w = pte[PTE_W];
    x = pte[PTE_X];
    leaf = r | x;

    page_base = '0;
    page_base[PPN_MSB-PPN_LSB+PAGE_SHIFT:PAGE_SHIFT] = pte[PPN_MSB:PPN_LSB];
    va_ext = {{(BUS_DATA_WIDTH-VA_WIDTH){1'b0}}, va};

    // Offset width grows by one VPN field per level above the 4K leaf.
    off_bits = 6'(PAGE_SHIFT + VPN_BITS*int'(level));
    off_mask = (64'd1 << off_bits) - 64'd1;

    // page_base has zero page-offset bits, so only ppn[9L-1:0] can hit here.
    misaligned = |(page_base & off_mask);

    fault = ~v | (~r & w) | (~leaf & (level == 2'd0)) | (leaf & misaligned);
    pa = (page_base & ~off_mask) | (va_ext & off_mask);
    next_base = page_base;
  end

endmodule

// File: rtl/page_table_walker.sv
// Multi-level (3/4) page-table walker: fetches one line per level over the
// system bus, keeps the addressed PTE beat and returns PA/leaf PTE or a fault.
module page_table_walker
  import ptw_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      walk_req_valid,
  output logic                      walk_req_ready,
  input  logic [VA_WIDTH-1:0]       walk_va,
  input  logic [2:0]                walk_levels,
  input  logic [BUS_DATA_WIDTH-1:0] ptbr,
  output logic                      walk_resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] walk_resp_pa,
  output logic [BUS_DATA_WIDTH-1:0] walk_resp_pte,
  output logic [2:0]                walk_resp_level,
  output logic                      walk_resp_fault,
  output logic                      abtr_reqcyc,
  input  logic                      abtr_grant,
  output logic                      bus_busy,
  output logic                      main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  input  logic                      main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  output logic                      main_bus_respack,
  output ptw_state_e                dbg_state
);

  // Handshake: a request is taken on the rising edge where walk_req_valid and
  // walk_req_ready are both high; walk_resp_valid is a one-cycle pulse with no
  // back-pressure, and each matching-tag response beat is acked in its own cycle.

  ptw_state_e                state, state_nxt;
  logic [VA_WIDTH-1:0]       va_q;
  logic [1:0]                level_q;
  logic [BUS_DATA_WIDTH-1:0] base_q;
  logic [BUS_DATA_WIDTH-1:0] pte_q;
  logic [2:0]                beat_cnt;
  logic [BUS_DATA_WIDTH-1:0] pte_addr;
  logic                      levels_ok;
  logic                      beat_hit;
  logic                      last_beat;
  logic                      chk_leaf;
  logic                      chk_fault;
  logic [BUS_DATA_WIDTH-1:0] chk_pa;
  logic [BUS_DATA_WIDTH-1:0] chk_next_base;

  assign dbg_state = state;
  assign levels_ok = (walk_levels == 3'd3) || (walk_levels == 3'd4);
  assign pte_addr  = base_q + {{(BUS_DATA_WIDTH-VPN_BITS-3){1'b0}}, vpn_at(va_q, level_q), 3'b000};
  assign beat_hit  = main_bus_respcyc && (main_bus_resptag == PTW_TAG) &&
                     ((state == ST_WAIT) || (state == ST_RESP));
  assign last_beat = (beat_cnt == 3'(LINE_BEATS-1));

  pte_check u_pte_check (
    .pte       (pte_q),
    .level     (level_q),
    .va        (va_q),
    .leaf      (chk_leaf),
    .fault     (chk_fault),
    .pa        (chk_pa),
    .next_base (chk_next_base)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (walk_req_valid) state_nxt = levels_ok ? ST_ARB : ST_DONE;
      ST_ARB:   if (abtr_grant) state_nxt = ST_REQ;
      ST_REQ:   state_nxt = ST_WAIT;
      // The first matching beat is consumed in WAIT, so RESP sees the other seven.
      ST_WAIT:  if (beat_hit) state_nxt = last_beat ? ST_CHECK : ST_RESP;
      ST_RESP:  if (beat_hit && last_beat) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (chk_leaf || chk_fault) ? ST_DONE : ST_REQ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    walk_req_ready   = (state == ST_IDLE);
    walk_resp_valid  = (state == ST_DONE);
    abtr_reqcyc      = (state == ST_ARB) || (state == ST_REQ) || (state == ST_WAIT) ||
                       (state == ST_RESP) || (state == ST_CHECK);
    bus_busy         = (state == ST_REQ) || (state == ST_WAIT) ||
                       (state == ST_RESP) || (state == ST_CHECK);
    main_bus_reqcyc  = (state == ST_REQ);
    main_bus_req     = main_bus_reqcyc ? {pte_addr[BUS_DATA_WIDTH-1:6], 6'b0} : '0;
    main_bus_reqtag  = main_bus_reqcyc ? PTW_TAG : '0;
    main_bus_respack = beat_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      va_q            <= '0;
      level_q         <= '0;
      base_q          <= '0;
      pte_q           <= '0;
      beat_cnt        <= '0;
      walk_resp_pa    <= '0;
      walk_resp_pte   <= '0;
      walk_resp_level <= '0;
      walk_resp_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (walk_req_valid) begin
            va_q            <= walk_va;
            base_q          <= ptbr;
            level_q         <= (walk_levels == 3'd4) ? 2'd3 : 2'd2;
            walk_resp_pa    <= '0;
            walk_resp_pte   <= '0;
            walk_resp_level <= '0;
            // An unsupported level count goes straight to DONE as a fault.
            walk_resp_fault <= ~levels_ok;
          end
        end
        ST_REQ: beat_cnt <= '0;
        ST_WAIT, ST_RESP: begin
          if (beat_hit) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (beat_cnt == pte_addr[5:3]) pte_q <= main_bus_resp;
          end
        end
        ST_CHECK: begin
          if (chk_leaf || chk_fault) begin
            walk_resp_pa    <= chk_fault ? '0 : chk_pa;
            walk_resp_pte   <= pte_q;
            walk_resp_level <= {1'b0, level_q};
            walk_resp_fault <= chk_fault;
          end else begin
            base_q  <= chk_next_base;
            level_q <= level_q - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Bench for page_table_walker: sparse memory, bus responder, arbiter, a
// specification-level walk model feeding expected queues, and one compare process.
module tb_page_table_walker;
  import ptw_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      walk_req_valid;
  logic                      walk_req_ready;
  logic [VA_WIDTH-1:0]       walk_va;
  logic [2:0]                walk_levels;
  logic [BUS_DATA_WIDTH-1:0] ptbr;
  logic                      walk_resp_valid;
  logic [BUS_DATA_WIDTH-1:0] walk_resp_pa;
  logic [BUS_DATA_WIDTH-1:0] walk_resp_pte;
  logic [2:0]                walk_resp_level;
  logic                      walk_resp_fault;
  logic                      abtr_reqcyc;
  logic                      abtr_grant;
  logic                      bus_busy;
  logic                      main_bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] main_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag;
  logic                      main_bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] main_bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag;
  logic                      main_bus_respack;
  ptw_state_e                dbg_state;

  localparam logic [BUS_TAG_WIDTH-1:0] FOREIGN_TAG = 13'h0AAA;

  typedef struct {
    logic [63:0] pa;
    logic [63:0] pte;
    logic [2:0]  lvl;
    logic        fault;
    int          nreq;
  } res_t;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_q[$];
  res_t        exp_res_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  bit          drop_resp = 0;
  bit          foreign_en = 0;

  page_table_walker dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .walk_req_valid   (walk_req_valid),
    .walk_req_ready   (walk_req_ready),
    .walk_va          (walk_va),
    .walk_levels      (walk_levels),
    .ptbr             (ptbr),
    .walk_resp_valid  (walk_resp_valid),
    .walk_resp_pa     (walk_resp_pa),
    .walk_resp_pte    (walk_resp_pte),
    .walk_resp_level  (walk_resp_level),
    .walk_resp_fault  (walk_resp_fault),
    .abtr_reqcyc      (abtr_reqcyc),
    .abtr_grant       (abtr_grant),
    .bus_busy         (bus_busy),
    .main_bus_reqcyc  (main_bus_reqcyc),
    .main_bus_req     (main_bus_req),
    .main_bus_reqtag  (main_bus_reqtag),
    .main_bus_respcyc (main_bus_respcyc),
    .main_bus_resp    (main_bus_resp),
    .main_bus_resptag (main_bus_resptag),
    .main_bus_respack (main_bus_respack),
    .dbg_state        (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'h0;
  endfunction

  // Walk model: follows the table rules on the sparse memory directly.
  task automatic model_walk(input logic [63:0] va, input logic [2:0] levels,
                            input logic [63:0] root, output res_t r);
    logic [63:0] base, addr, pte, ppn_base, page;
    r.pa = 0; r.pte = 0; r.lvl = 0; r.fault = 0; r.nreq = 0;
    base = root;
    if (levels != 3'd3 && levels != 3'd4) begin
      r.fault = 1'b1;
    end else begin
      for (int l = int'(levels) - 1; l >= 0; l--) begin
        addr = base + ((va >> (12 + 9*l)) & 64'h1FF) * 64'd8;
        exp_q.push_back(addr & ~64'h3F);
        r.nreq++;
        pte = mem_rd(addr);
        r.pte = pte;
        r.lvl = 3'(l);
        ppn_base = ((pte >> 10) & ((64'd1 << 44) - 64'd1)) << 12;
        page = 64'd1 << (12 + 9*l);
        if (!pte[0] || (!pte[1] && pte[2])) begin
          r.fault = 1'b1;
          break;
        end
        if (pte[1] || pte[3]) begin
          if (ppn_base % page != 0) r.fault = 1'b1;
          else r.pa = ppn_base + (va % page);
          break;
        end
        if (l == 0) begin
          r.fault = 1'b1;
          break;
        end
        base = ppn_base;
      end
    end
    exp_res_q.push_back(r);
  endtask

  // Arbiter: grants a pending request with a random delay.
  initial begin
    abtr_grant = 1'b0;
    forever begin
      @(negedge clk);
      abtr_grant = abtr_reqcyc && ($urandom_range(0, 1) == 1);
    end
  end

  // Bus responder: returns the 8 beats of each requested line.
  initial begin
    logic [63:0] line;
    main_bus_respcyc = 1'b0;
    main_bus_resp    = '0;
    main_bus_resptag = '0;
    forever begin
      @(negedge clk);
      if (reset_n && main_bus_reqcyc && !drop_resp) begin
        line = main_bus_req;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        for (int i = 0; i < LINE_BEATS; i++) begin
          if (foreign_en && (i % 2 == 0)) begin
            @(posedge clk); #1;
            main_bus_respcyc = 1'b1;
            main_bus_resptag = FOREIGN_TAG;
            main_bus_resp    = 64'h5555_0000_0000_0001;
          end
          @(posedge clk); #1;
          main_bus_respcyc = 1'b1;
          main_bus_resptag = PTW_TAG;
          main_bus_resp    = mem_rd(line + 64'(8*i));
        end
        @(posedge clk); #1;
        main_bus_respcyc = 1'b0;
        main_bus_resptag = '0;
        main_bus_resp    = '0;
      end
    end
  end

  // Compare process: requests, acks and results against the model queues.
  res_t mr;
  always @(negedge clk) begin
    if (reset_n) begin
      if (main_bus_reqcyc) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_req: got 0x%0h, required no request", main_bus_req);
        end else begin
          check("req_addr", main_bus_req, exp_q.pop_front());
        end
        check("req_tag", 64'(main_bus_reqtag), 64'(PTW_TAG));
      end
      if (main_bus_respcyc)
        check("respack", 64'(main_bus_respack), 64'(main_bus_resptag == PTW_TAG));
      if (main_bus_respack) ack_cnt++;
      if (walk_resp_valid) begin
        if (exp_res_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_resp: got pa 0x%0h, required no response", walk_resp_pa);
        end else begin
          mr = exp_res_q.pop_front();
          check("resp_pa", walk_resp_pa, mr.pa);
          check("resp_pte", walk_resp_pte, mr.pte);
          check("resp_level", 64'(walk_resp_level), 64'(mr.lvl));
          check("resp_fault", 64'(walk_resp_fault), 64'(mr.fault));
          check("resp_ready_low", 64'(walk_req_ready), 64'd0);
        end
      end
    end
  end

  // Driver tasks
  task automatic start_walk(input logic [63:0] va, input logic [2:0] levels, input logic [63:0] root);
    @(posedge clk); #1;
    walk_req_valid = 1'b1;
    walk_va        = va[VA_WIDTH-1:0];
    walk_levels    = levels;
    ptbr           = root;
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
  endtask

  task automatic run_walk(input string name, input logic [63:0] va, input logic [2:0] levels,
                          input logic [63:0] root, output res_t r, output int lat);
    model_walk(va, levels, root, r);
    ack_cnt = 0;
    start_walk(va, levels, root);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!walk_resp_valid && lat < 2000);
    #1;
    if (lat >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no response after %0d cycles, required one", name, lat);
      exp_q.delete();
      exp_res_q.delete();
    end
    check({name, "_acks"}, 64'(ack_cnt), 64'(8 * r.nreq));
    check({name, "_reqs_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 64'(walk_req_ready), 64'd1);
    check({name, "_resp_valid"}, 64'(walk_resp_valid), 64'd0);
    check({name, "_resp_pa"}, walk_resp_pa, 64'd0);
    check({name, "_resp_pte"}, walk_resp_pte, 64'd0);
    check({name, "_resp_level"}, 64'(walk_resp_level), 64'd0);
    check({name, "_resp_fault"}, 64'(walk_resp_fault), 64'd0);
    check({name, "_abtr_reqcyc"}, 64'(abtr_reqcyc), 64'd0);
    check({name, "_bus_busy"}, 64'(bus_busy), 64'd0);
    check({name, "_reqcyc"}, 64'(main_bus_reqcyc), 64'd0);
    check({name, "_req"}, main_bus_req, 64'd0);
    check({name, "_reqtag"}, 64'(main_bus_reqtag), 64'd0);
    check({name, "_respack"}, 64'(main_bus_respack), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic put_pte(input logic [63:0] a, input logic [63:0] v);
    mem[a] = v;
  endtask

  task automatic fill_noise();
    logic [63:0] keys[$];
    logic [63:0] line;
    foreach (mem[k]) keys.push_back(k);
    foreach (keys[j]) begin
      line = keys[j] & ~64'h3F;
      for (int i = 0; i < LINE_BEATS; i++)
        if (!mem.exists(line + 64'(8*i))) mem[line + 64'(8*i)] = 64'hF000_0000_0000_0000 | (line + 64'(8*i));
    end
  endtask

  // Main sequence
  initial begin
    res_t r;
    int   lat;
    int   n;
    walk_req_valid = 1'b0;
    walk_va        = '0;
    walk_levels    = '0;
    ptbr           = '0;

    put_pte(64'h8000_0000, 64'h2000_0401);
    put_pte(64'h8000_1000, 64'h2000_0801);
    put_pte(64'h8000_2488, 64'h2000_0C01);
    put_pte(64'h8000_3A28, 64'h2AF3_780F);
    put_pte(64'h9000_0008, 64'h2400_0401);
    put_pte(64'h9000_1008, 64'h1008_0003);
    put_pte(64'hA000_0000, 64'h2800_0401);
    put_pte(64'hA000_1000, 64'hDEAD_BEE0);
    put_pte(64'hB000_0000, 64'h2C00_0401);
    put_pte(64'hB000_1000, 64'h1000_040B);
    put_pte(64'hC000_0000, 64'h3000_0401);
    put_pte(64'hC000_1488, 64'h3000_0801);
    put_pte(64'hC000_2A28, 64'h0000_0001);
    put_pte(64'hD000_0000, 64'h0000_0005);
    fill_noise();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_walk("t1_4lvl", 64'h0000_1234_5678, 3'd4, 64'h8000_0000, r, lat);
    check("t1_pin_pa", r.pa, 64'hABCD_E678);
    check("t1_pin_nreq", 64'(r.nreq), 64'd4);
    check("t1_pin_fault", 64'(r.fault), 64'd0);

    run_walk("t2_2mb", 64'h0000_4020_3456, 3'd3, 64'h9000_0000, r, lat);
    check("t2_pin_pa", r.pa, 64'h4020_3456);
    check("t2_pin_level", 64'(r.lvl), 64'd1);
    check("t2_pin_nreq", 64'(r.nreq), 64'd2);

    run_walk("t3_vzero", 64'h0000_1234_5678, 3'd4, 64'hA000_0000, r, lat);
    check("t3_pin_fault", 64'(r.fault), 64'd1);
    check("t3_pin_level", 64'(r.lvl), 64'd2);
    check("t3_pin_pte", r.pte, 64'hDEAD_BEE0);
    check("t3_pin_nreq", 64'(r.nreq), 64'd2);

    run_walk("t4_misalign", 64'h0000_1234_5678, 3'd4, 64'hB000_0000, r, lat);
    check("t4_pin_fault", 64'(r.fault), 64'd1);
    check("t4_pin_level", 64'(r.lvl), 64'd2);

    foreign_en = 1'b1;
    run_walk("t5_foreign", 64'h0000_1234_5678, 3'd4, 64'h8000_0000, r, lat);
    check("t5_pin_pa", r.pa, 64'hABCD_E678);
    foreign_en = 1'b0;

    run_walk("t6_badlvl", 64'h0000_1234_5678, 3'd5, 64'h8000_0000, r, lat);
    check("t6_latency", 64'(lat), 64'd1);
    check("t6_pin_fault", 64'(r.fault), 64'd1);
    check("t6_pin_nreq", 64'(r.nreq), 64'd0);

    run_walk("t7_wnor", 64'h0000_1234_5678, 3'd3, 64'hD000_0000, r, lat);
    check("t7_pin_fault", 64'(r.fault), 64'd1);
    check("t7_pin_level", 64'(r.lvl), 64'd2);

    run_walk("t8_ptr_l0", 64'h0000_1234_5678, 3'd3, 64'hC000_0000, r, lat);
    check("t8_pin_fault", 64'(r.fault), 64'd1);
    check("t8_pin_level", 64'(r.lvl), 64'd0);
    check("t8_pin_pte", r.pte, 64'h1);

    // Reset while the walker waits for its first line.
    drop_resp = 1'b1;
    model_walk(64'h0000_1234_5678, 3'd4, 64'h8000_0000, r);
    start_walk(64'h0000_1234_5678, 3'd4, 64'h8000_0000);
    n = 0;
    while (!main_bus_reqcyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t9_req_seen", 64'(main_bus_reqcyc), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t9_rst");
    exp_q.delete();
    exp_res_q.delete();
    @(posedge clk); #1;
    reset_n   = 1'b1;
    drop_resp = 1'b0;
    run_walk("t9_after", 64'h0000_1234_5678, 3'd4, 64'h8000_0000, r, lat);
    check("t9_pin_pa", r.pa, 64'hABCD_E678);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
